// File: rtl/valid_ready_memory.sv
`default_nettype none
// ============================================================================
//  Module   : valid_ready_memory
//  Brief    : Single-port synchronous scratch RAM with a valid/ready request
//             handshake. One write or one read per accepted request; read
//             data is registered and valid one clock after acceptance.
//  Revision : 1.0 - initial release
// ============================================================================
module valid_ready_memory #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_rd,
    input  logic [WIDTH-1:0]      w_data,
    output logic [WIDTH-1:0]      r_data,
    input  logic                  valid,
    output logic                  ready
);

    // Control states: RESET holds ready low, ACTIVE accepts one request per cycle.
    localparam logic [0:0] c_ST_RESET  = 1'b0;
    localparam logic [0:0] c_ST_ACTIVE = 1'b1;

    // Storage array; the name mem is kept stable for hierarchical backdoor access.
    logic [WIDTH-1:0] mem [0:DEPTH-1];

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_rd_data;

    logic             w_addr_ok;
    logic             w_xfer;
    logic             w_wr_en;
    logic             w_rd_en;

    // Address range qualification. A power-of-two depth covers every code of
    // the address bus, so no comparator is needed in that case.
    generate
        if ((1 << ADDR_WIDTH) == DEPTH) begin : g_full_range
            assign w_addr_ok = 1'b1;
        end else begin : g_partial_range
            assign w_addr_ok = ({{(32-ADDR_WIDTH){1'b0}}, addr} < 32'(DEPTH));
        end
    endgenerate

    // A transfer needs the registered ready from before the edge, so the
    // request is never accepted on the edge that leaves reset.
    assign w_xfer  = valid && (r_state == c_ST_ACTIVE);
    assign w_wr_en = w_xfer &&  wr_rd && w_addr_ok;
    assign w_rd_en = w_xfer && !wr_rd;

    // Two-state control: any reset edge returns to RESET, first clean edge goes ACTIVE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RESET;
        end else begin
            r_state <= c_ST_ACTIVE;
        end
    end

    // Storage update: cleared on reset, written on an accepted in-range write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            mem[addr] <= w_data;
        end
    end

    // Registered read data: loads only on an accepted read, holds otherwise;
    // out-of-range reads return zero so no undefined word ever reaches the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (w_rd_en) begin
            r_rd_data <= w_addr_ok ? mem[addr] : '0;
        end
    end

    assign r_data = r_rd_data;
    assign ready  = (r_state == c_ST_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_valid_ready_memory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_valid_ready_memory
//  Brief    : Directed self-checking bench for valid_ready_memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_valid_ready_memory;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 16;
    localparam int ADDR_WIDTH = 4;

    logic                  clk;
    logic                  rst;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_rd;
    logic [WIDTH-1:0]      w_data;
    logic [WIDTH-1:0]      r_data;
    logic                  valid;
    logic                  ready;

    int errors = 0;
    int checks = 0;

    logic [127:0] msg;
    logic [7:0]   exp_byte;

    valid_ready_memory #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wr_rd  (wr_rd),
        .w_data (w_data),
        .r_data (r_data),
        .valid  (valid),
        .ready  (ready)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one cycle of inputs, then advance to 1 time unit after the edge.
    task automatic step(input logic r, input logic v, input logic w,
                        input logic [ADDR_WIDTH-1:0] a, input logic [WIDTH-1:0] d);
        rst    = r;
        valid  = v;
        wr_rd  = w;
        addr   = a;
        w_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        msg = "HAPPY WORLD 2024";
        rst = 1'b1; valid = 1'b0; wr_rd = 1'b0; addr = '0; w_data = '0;

        // ---- 1. Reset with a write request present: request ignored ----
        step(1'b1, 1'b1, 1'b1, 4'd0, 8'h55);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rdata", {24'd0, r_data}, 32'h00);
        check("rst_mem0", {24'd0, dut.mem[0]}, 32'h00);
        step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        check("rel_ready", {31'd0, ready}, 32'd1);
        check("rel_mem0", {24'd0, dut.mem[0]}, 32'h00);

        // ---- 2. Forward write of the message, then back-to-back reads ----
        for (int i = 0; i < 16; i++) begin
            exp_byte = msg[127-8*i -: 8];
            step(1'b0, 1'b1, 1'b1, 4'(i), exp_byte);
        end
        check("wr_rdata_hold", {24'd0, r_data}, 32'h00);
        for (int i = 0; i < 16; i++) begin
            exp_byte = msg[127-8*i -: 8];
            step(1'b0, 1'b1, 1'b0, 4'(i), 8'h00);
            check($sformatf("msg_rd%0d", i), {24'd0, r_data}, {24'd0, exp_byte});
        end
        check("msg_rd0_is_H", {24'd0, dut.mem[0]}, 32'h48);
        check("ready_steady", {31'd0, ready}, 32'd1);

        // ---- 3a. Reset, half range write, full range read ----
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        check("half_rst_ready", {31'd0, ready}, 32'd0);
        check("half_rst_rdata", {24'd0, r_data}, 32'h00);
        step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 4'(i), 8'hA0 + 8'(i));
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 4'(i), 8'h00);
            check($sformatf("half_rd%0d", i), {24'd0, r_data},
                  (i < 8) ? (32'hA0 + 32'(i)) : 32'h00);
        end

        // ---- 3b. Reset, quarter range write, read 0..7 ----
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 4'(i), 8'hA0 + 8'(i));
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 4'(i), 8'h00);
            check($sformatf("qtr_rd%0d", i), {24'd0, r_data},
                  (i < 4) ? (32'hA0 + 32'(i)) : 32'h00);
        end

        // ---- 4. Pattern 0x10+i written, read back in reverse order ----
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 4'(i), 8'h10 + 8'(i));
        for (int i = 15; i >= 0; i--) begin
            step(1'b0, 1'b1, 1'b0, 4'(i), 8'h00);
            check($sformatf("p10_rd%0d", i), {24'd0, r_data}, 32'h10 + 32'(i));
        end

        // ---- 5. Frontdoor write 0xFF-addr, backdoor dump of the array ----
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 4'(i), 8'hFF - 8'(i));
        for (int i = 0; i < 16; i++) begin
            check($sformatf("dump%0d", i), {24'd0, dut.mem[i]}, 32'hFF - 32'(i));
        end

        // ---- 6. Back-to-back write/read and idle cycles ----
        step(1'b0, 1'b1, 1'b1, 4'd5, 8'h3C);
        step(1'b0, 1'b1, 1'b0, 4'd5, 8'h00);
        check("b2b_rd5", {24'd0, r_data}, 32'h3C);
        step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        check("idle_rd_hold", {24'd0, r_data}, 32'h3C);
        step(1'b0, 1'b0, 1'b1, 4'd5, 8'h99);
        check("idle_wr_nomem", {24'd0, dut.mem[5]}, 32'h3C);
        step(1'b0, 1'b1, 1'b1, 4'd6, 8'h77);
        check("wr_keeps_rdata", {24'd0, r_data}, 32'h3C);
        step(1'b0, 1'b1, 1'b0, 4'd6, 8'h00);
        check("rd6", {24'd0, r_data}, 32'h77);
        step(1'b0, 1'b1, 1'b0, 4'd0, 8'h00);
        check("rd0_after", {24'd0, r_data}, 32'hFF);

        // ---- 7. Reset mid-operation overrides a read; release edge ignores request ----
        step(1'b1, 1'b1, 1'b0, 4'd6, 8'h00);
        check("mid_rst_rdata", {24'd0, r_data}, 32'h00);
        check("mid_rst_ready", {31'd0, ready}, 32'd0);
        check("mid_rst_mem6", {24'd0, dut.mem[6]}, 32'h00);
        step(1'b0, 1'b1, 1'b1, 4'd2, 8'hEE);
        check("release_ready", {31'd0, ready}, 32'd1);
        check("release_nowr", {24'd0, dut.mem[2]}, 32'h00);
        step(1'b0, 1'b1, 1'b1, 4'd3, 8'hC3);
        check("first_acc_wr", {24'd0, dut.mem[3]}, 32'hC3);
        step(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
        check("first_acc_rd", {24'd0, r_data}, 32'hC3);
        step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
